i2c_expander_target: RTL and testbench

- Synthesizable I2C target (responder) that emulates a PCF8574-style 8-bit quasi-bidirectional I/O expander at a fixed 7-bit address.
- It is the other end of the bus from our write-only I2C master. It serves as an in-FPGA stand-in for the LCD backpack, for loopback tests, and as a general register target.
- Write transfers update an 8-bit output port. Read transfers return a snapshot of an 8-bit input port.
- SCL/SDA are oversampled on the system clock; no clock stretching.

---
 rtl/i2c_expander_target.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_expander_target.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_expander_target.sv
// I2C target emulating a PCF8574-style 8-bit I/O expander.
// Oversampled SCL/SDA, open-drain SDA, no clock stretching.
module i2c_expander_target #(
    parameter logic [6:0] ADDR          = 7'h3F,
    parameter logic [7:0] RESET_OUT     = 8'hFF,
    parameter int         FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] port_in,
    output logic [7:0] port_out,
    output logic       wr_strobe,
    output logic       rd_strobe,
    output logic       busy,
    output logic       nack_out
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] LIM = FW'(FILTER_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR_S, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    // bit 0 = scl, bit 1 = sda
    logic [1:0]    s1, s2, f, fd;
    logic [FW-1:0] cnt [2];

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] rx, rx_n, tx, tx_n, port_out_n;
    logic       rw, rw_n, acked, acked_n, sda_low, sda_low_n;
    logic       wr_strobe_n, rd_strobe_n, busy_n, nack_out_n;

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

    // Synchronize both lines, then accept a new level only once it has held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1     <= 2'b11;
            s2     <= 2'b11;
            f      <= 2'b11;
            fd     <= 2'b11;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            s1 <= {sda, scl};
            s2 <= s1;
            fd <= f;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == f[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LIM) begin
                    f[i]   <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign scl_f     = f[0];
    assign sda_f     = f[1];
    assign scl_rise  = f[0] & ~fd[0];
    assign scl_fall  = ~f[0] & fd[0];
    assign start_det = fd[1] & ~f[1] & f[0] & fd[0];
    assign stop_det  = ~fd[1] & f[1] & f[0] & fd[0];

    // A START/STOP seen while pulling low releases the line at once.
    assign sda = (sda_low && !start_det && !stop_det) ? 1'b0 : 1'bz;

    // Protocol state and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx        <= '0;
            tx        <= '0;
            rw        <= 1'b0;
            acked     <= 1'b0;
            sda_low   <= 1'b0;
            port_out  <= RESET_OUT;
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            busy      <= 1'b0;
            nack_out  <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            rx        <= rx_n;
            tx        <= tx_n;
            rw        <= rw_n;
            acked     <= acked_n;
            sda_low   <= sda_low_n;
            port_out  <= port_out_n;
            wr_strobe <= wr_strobe_n;
            rd_strobe <= rd_strobe_n;
            busy      <= busy_n;
            nack_out  <= nack_out_n;
        end
    end

    // Next-state and output decode; bus conditions override every state.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        rx_n        = rx;
        tx_n        = tx;
        rw_n        = rw;
        acked_n     = acked;
        sda_low_n   = sda_low;
        port_out_n  = port_out;
        wr_strobe_n = 1'b0;
        rd_strobe_n = 1'b0;
        busy_n      = busy;
        nack_out_n  = 1'b0;
        if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            sda_low_n = 1'b0;
            busy_n    = 1'b0;
        end else if (start_det) begin
            state_n   = ADDR_S;
            bit_cnt_n = '0;
            sda_low_n = 1'b0;
            busy_n    = 1'b0;
        end else begin
            unique case (state)
                IDLE, IGNORE: begin
                    sda_low_n = 1'b0;
                end
                ADDR_S: begin
                    if (scl_rise) begin
                        rx_n      = {rx[6:0], sda_f};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rw_n    = sda_f;
                            state_n = (rx[6:0] == ADDR) ? ADDR_ACK : IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_low) begin
                            sda_low_n = 1'b1;
                            busy_n    = 1'b1;
                        end else begin
                            bit_cnt_n = '0;
                            if (rw) begin
                                state_n     = RD_DATA;
                                tx_n        = port_in;
                                rd_strobe_n = 1'b1;
                                sda_low_n   = ~port_in[7];
                            end else begin
                                state_n   = WR_DATA;
                                sda_low_n = 1'b0;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        rx_n      = {rx[6:0], sda_f};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            port_out_n  = {rx[6:0], sda_f};
                            wr_strobe_n = 1'b1;
                            state_n     = WR_ACK;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_low) begin
                            sda_low_n = 1'b1;
                        end else begin
                            sda_low_n = 1'b0;
                            bit_cnt_n = '0;
                            state_n   = WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            sda_low_n = 1'b0;
                            acked_n   = 1'b0;
                            state_n   = RD_ACK;
                        end else begin
                            tx_n      = {tx[6:0], 1'b0};
                            sda_low_n = ~tx[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_f) begin
                            nack_out_n = 1'b1;
                            sda_low_n  = 1'b0;
                            state_n    = IGNORE;
                        end else begin
                            acked_n = 1'b1;
                        end
                    end else if (scl_fall && acked) begin
                        tx_n        = port_in;
                        rd_strobe_n = 1'b1;
                        sda_low_n   = ~port_in[7];
                        bit_cnt_n   = '0;
                        state_n     = RD_DATA;
                    end
                end
                default: begin
                    state_n   = IDLE;
                    sda_low_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_expander_target.sv
// Bench for i2c_expander_target: bit-banged master on a pulled-up bus,
// transaction-level reference model of the expander.
module tb_i2c_expander_target;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] port_in = 8'h00;
    logic [7:0] port_out;
    logic       wr_strobe, rd_strobe, busy, nack_out;
    wire        sda;

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_expander_target dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl       (m_scl),
        .sda       (sda),
        .port_in   (port_in),
        .port_out  (port_out),
        .wr_strobe (wr_strobe),
        .rd_strobe (rd_strobe),
        .busy      (busy),
        .nack_out  (nack_out)
    );

    int n_chk = 0, n_pass = 0;
    int wr_cnt = 0, rd_cnt = 0, nack_cnt = 0;
    int exp_wr = 0, exp_rd = 0, exp_nack = 0;
    logic [7:0] mdl_out = 8'hFF;
    logic [7:0] wr_log[$];
    logic [7:0] exp_q[$];
    logic [7:0] pre_q[$];

    // Strobe monitor: every strobe cycle counts, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_strobe) begin
                wr_cnt++;
                wr_log.push_back(port_out);
            end
            if (rd_strobe) rd_cnt++;
            if (nack_out) nack_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic bus();
        return (sda === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [7:0] next_val();
        if (pre_q.size() > 0) return pre_q.pop_front();
        return 8'($urandom);
    endfunction

    task automatic wq();
        repeat (10) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, input logic glitch, output logic r);
        m_scl = 1'b0;
        wq();
        m_sda = b;
        if (glitch) begin
            @(negedge clk) m_scl = 1'b1;
            @(negedge clk) m_scl = 1'b0;
        end
        wq();
        m_scl = 1'b1;
        wq();
        r = bus();
        wq();
    endtask

    task automatic start_c();
        m_scl = 1'b0;
        wq();
        m_sda = 1'b1;
        wq();
        m_scl = 1'b1;
        wq();
        m_sda = 1'b0;
        wq();
    endtask

    task automatic stop_c();
        m_scl = 1'b0;
        wq();
        m_sda = 1'b0;
        wq();
        m_scl = 1'b1;
        wq();
        m_sda = 1'b1;
        wq();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic glitch,
                             output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], glitch && i == 4, r);
        clk_bit(1'b1, 1'b0, ack);
    endtask

    task automatic sync_model();
        check("wr_cnt", wr_cnt, exp_wr);
        check("rd_cnt", rd_cnt, exp_rd);
        check("nack_cnt", nack_cnt, exp_nack);
        check("port_out", port_out, mdl_out);
        while (wr_log.size() > 0 && exp_q.size() > 0)
            check("wr_seq", wr_log.pop_front(), exp_q.pop_front());
        wr_log.delete();
        exp_q.delete();
    endtask

    task automatic xfer(input logic [6:0] a, input logic rd, input int n,
                        input logic glitch, input logic stop_after);
        logic       ack, r, match;
        logic [7:0] d, e;
        match = (a == 7'h3F);
        if (rd) port_in = next_val();
        start_c();
        send_byte({a, rd}, glitch, ack);
        check("addr_ack", ack, !match);
        check("busy_addr", busy, match);
        for (int k = 0; k < n; k++) begin
            if (!rd) begin
                d = next_val();
                send_byte(d, 1'b0, ack);
                check("data_ack", ack, !match);
                if (match) begin
                    mdl_out = d;
                    exp_q.push_back(d);
                    exp_wr++;
                end
            end else begin
                e = match ? port_in : 8'hFF;
                for (int i = 7; i >= 0; i--) begin
                    clk_bit(1'b1, 1'b0, r);
                    d[i] = r;
                end
                check("rd_byte", d, e);
                if (match) exp_rd++;
                if (k < n - 1) begin
                    port_in = next_val();
                    clk_bit(1'b0, 1'b0, r);
                end else begin
                    clk_bit(1'b1, 1'b0, r);
                    if (match) exp_nack++;
                    m_scl = 1'b0;
                    wq();
                    check("nack_rel", bus(), 1'b1);
                end
            end
        end
        if (stop_after) begin
            stop_c();
            wq();
            check("busy_stop", busy, 1'b0);
        end else begin
            check("busy_hold", busy, match);
        end
        sync_model();
    endtask

    initial begin
        logic r;
        logic [7:0] b;
        repeat (5) @(negedge clk);
        check("rst_out", port_out, 8'hFF);
        check("rst_wr", wr_strobe, 1'b0);
        check("rst_rd", rd_strobe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_nack", nack_out, 1'b0);
        check("rst_sda", bus(), 1'b1);
        reset_n = 1'b1;
        wq();

        pre_q = '{8'hA5};
        xfer(7'h3F, 1'b0, 1, 1'b0, 1'b1);
        xfer(7'h27, 1'b0, 1, 1'b0, 1'b1);
        pre_q = '{8'h11, 8'h22, 8'h33};
        xfer(7'h3F, 1'b0, 3, 1'b0, 1'b1);
        pre_q = '{8'h5C, 8'hC3};
        xfer(7'h3F, 1'b1, 2, 1'b0, 1'b1);
        pre_q = '{8'hAA};
        xfer(7'h3F, 1'b0, 1, 1'b0, 1'b0);
        pre_q = '{8'h0F};
        xfer(7'h3F, 1'b1, 1, 1'b0, 1'b1);

        start_c();
        b = 8'h7E;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], 1'b0, r);
        m_scl = 1'b0;
        m_sda = 1'b1;
        wq();
        check("ack_drv", bus(), 1'b0);
        reset_n = 1'b0;
        #1;
        check("rst_rel", bus(), 1'b1);
        check("rst_out2", port_out, 8'hFF);
        check("rst_busy2", busy, 1'b0);
        mdl_out = 8'hFF;
        m_scl = 1'b1;
        wq();
        reset_n = 1'b1;
        wq();

        xfer(7'h3F, 1'b0, 1, 1'b1, 1'b1);

        for (int t = 0; t < 14; t++) begin
            xfer(($urandom_range(0, 1) != 0) ? 7'h3F : 7'($urandom),
                 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
                 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
